// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the imem request/ready handshake feeding IF/ID.
// Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic        fetch_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic        fetch_err
);

  // state   | meaning
  // S_BOOT  | first cycle after reset, no request
  // S_FETCH | request outstanding at pc
  // S_HOLD  | downstream stalled, replay hold_buf
  // S_DRAIN | redirect arrived mid-request; finish and drop the old fetch
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} state_t;

  localparam logic [7:0] WAIT_LIM8 = WAIT_LIMIT[7:0];

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] redirect_pc;
  logic        redirect_pending;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target    = branch_target & 32'hFFFF_FFFC;
  assign pc_inc    = pc + 32'd4;
  assign wait_nxt  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign imem_req  = (state == S_FETCH) || redirect_pending;
  assign imem_addr = pc;
  assign pc_out    = pc;

  // A redirect always kills the instruction presented this cycle.
  always_comb begin
    fetch_valid = 1'b0;
    ins_out     = '0;
    case (state)
      S_FETCH: begin
        if (imem_ready && !branch_taken) begin
          fetch_valid = 1'b1;
          ins_out     = imem_rdata;
        end
      end
      S_HOLD: begin
        if (!branch_taken) begin
          fetch_valid = 1'b1;
          ins_out     = hold_buf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_BOOT;
      pc               <= RESET_PC;
      hold_buf         <= '0;
      redirect_pc      <= '0;
      redirect_pending <= 1'b0;
      wait_cnt         <= '0;
      fetch_err        <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
          if (branch_taken) pc <= target;
        end
        S_FETCH: begin
          if (imem_ready) begin
            wait_cnt <= '0;
            if (branch_taken) begin
              pc <= target;
            end else if (pc_write) begin
              pc <= pc_inc;
            end else begin
              hold_buf <= imem_rdata;
              state    <= S_HOLD;
            end
          end else if (branch_taken) begin
            wait_cnt         <= '0;
            redirect_pc      <= target;
            redirect_pending <= 1'b1;
            state            <= S_DRAIN;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_LIM8) fetch_err <= 1'b1;
          end
        end
        S_HOLD: begin
          wait_cnt <= '0;
          if (branch_taken) begin
            pc       <= target;
            hold_buf <= '0;
            state    <= S_FETCH;
          end else if (pc_write) begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // The newest redirect wins even when it lands on the completing cycle.
          if (imem_ready) begin
            wait_cnt         <= '0;
            redirect_pending <= 1'b0;
            state            <= S_FETCH;
            pc               <= branch_taken ? target : redirect_pc;
          end else begin
            if (branch_taken) redirect_pc <= target;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_LIM8) fetch_err <= 1'b1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_valid && pc_write && !branch_taken) perf_fetched <= perf_fetched + 32'd1;
      if (imem_req && !imem_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the program counter and runs a request/ready handshake with instruction memory.
- Presents the current instruction and its PC to the IF/ID register, plus a valid flag.
- Honours the hazard unit's stall (pc_write) and the branch redirect from ID, including a redirect that arrives while a fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- WAIT_LIMIT, 16, consecutive cycles without imem_ready before fetch_err is raised (range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_write  input  1  1 = downstream accepts the instruction this cycle; 0 = stall.
- branch_taken  input  1  redirect request from ID; same cycle as the IF/ID flush.
- branch_target  input  32  redirect address; bits [1:0] ignored and treated as 0.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc, bits [1:0] always 0.
- imem_rdata  input  32  instruction word; sampled only when imem_req && imem_ready.
- imem_ready  input  1  memory completes the request this cycle.
- pc_out  output  32  PC of ins_out; feeds the pc input of IF/ID.
- ins_out  output  32  instruction to IF/ID; 32'b0 (NOP) when fetch_valid=0.
- fetch_valid  output  1  ins_out/pc_out hold a real instruction this cycle.
- fetch_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, state=S_BOOT.
  - imem_req=0, ins_out=0, fetch_valid=0, fetch_err=0, wait_cnt=0, redirect_pending=0, hold_buf=0.
  - Reset asserted mid-fetch abandons the request immediately; imem_req drops combinationally.
- States:
  - S_BOOT: imem_req=0, fetch_valid=0. Next cycle -> S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc. imem_req and imem_addr stay stable until imem_ready.
    - ready, pc_write=1, no redirect: ins_out=imem_rdata combinationally, fetch_valid=1; pc<=pc+4; stay S_FETCH. Back-to-back fetch gives 1 instruction per cycle with a zero-wait memory.
    - ready, pc_write=0: fetch_valid=1 and ins_out=imem_rdata this cycle; hold_buf<=imem_rdata; -> S_HOLD; pc unchanged.
    - not ready: fetch_valid=0, ins_out=0; wait_cnt increments (saturating at 255).
  - S_HOLD: imem_req=0, ins_out=hold_buf, fetch_valid=1, pc_out=pc. When pc_write=1: pc<=pc+4, -> S_FETCH.
  - S_DRAIN: imem_req=1, imem_addr = old pc (stable). fetch_valid=0. On imem_ready: data discarded, pc<=redirect_pc, redirect_pending<=0, -> S_FETCH.
- Redirect (branch_taken=1) has priority over pc_write:
  - In S_FETCH with imem_ready=1, or in S_HOLD: fetch_valid=0 that cycle; pc<={branch_target[31:2],2'b00}; hold_buf discarded; -> S_FETCH.
  - In S_FETCH with imem_ready=0: redirect_pc<=target, redirect_pending<=1, -> S_DRAIN.
  - In S_DRAIN: redirect_pc overwritten by the newest target. If imem_ready=1 in the same cycle, the newest target is used.
  - In S_BOOT: pc<=target; -> S_FETCH.
- Timeout:
  - wait_cnt clears on every imem_ready and on leaving S_FETCH/S_DRAIN.
  - When wait_cnt reaches WAIT_LIMIT, fetch_err<=1. It stays 1 until reset.
  - The request continues regardless of fetch_err.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0], counting accepted instructions (fetch_valid && pc_write && !branch_taken).
  - Adds outputs perf_stall[31:0], counting cycles with imem_req && !imem_ready.
  - Both counters reset to 0, wrap modulo 2^32, and are updated in every state.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready tied 1, pc_write=1 -> imem_addr sequence 0x0,0x4,0x8,0xC on consecutive cycles; ins_out mirrors imem_rdata; fetch_valid=1 from the 2nd cycle after reset.
- Stall: pc_write=0 for 3 cycles while fetching 0x8 with rdata 0x8C220004 -> S_HOLD; ins_out=0x8C220004 held, imem_req=0, pc_out=0x8. pc_write=1 -> next imem_addr=0xC.
- Redirect while waiting: imem_ready=0 at pc 0x10, branch_taken with target 0x43 -> S_DRAIN. When ready arrives the data is dropped (fetch_valid=0). Next imem_addr=0x40.
- Redirect coinciding with a stall in S_HOLD: branch_taken=1, pc_write=0, target 0x100 -> fetch_valid=0, next imem_addr=0x100, hold_buf discarded.
- Timeout: imem_ready=0 for 16 cycles, WAIT_LIMIT=16 -> fetch_err rises after 16 waiting cycles, stays 1 after ready returns, clears only on reset. A mid-wait reset pulse -> imem_req=0 and pc=RESET_PC at once.
- Wrap and perf: pc 0xFFFFFFFC fetched -> next 0x0. With FETCH_PERF_EN, 5 accepted fetches plus 3 wait cycles -> perf_fetched=5, perf_stall=3.
